// File: rtl/copier_ctrl_multi_if.sv
// Board-side signal bundle for the photocopier controller: job/sensor inputs
// from the switches and the status/7-seg outputs back to the board.
interface copier_ctrl_multi_if #(
    parameter int COUNT_BITS = 4,
    parameter int NTRAYS     = 2
);
    localparam int TRAY_BITS = (NTRAYS > 1) ? $clog2(NTRAYS) : 1;

    logic                  start;
    logic [COUNT_BITS-1:0] qty;
    logic [NTRAYS-1:0]     paper;
    logic                  jam;
    logic                  lid;
    logic                  cancel;

    logic                  copying;
    logic                  no_paper;
    logic                  jammed;
    logic                  done;
    logic [COUNT_BITS-1:0] remaining;
    logic [TRAY_BITS-1:0]  tray_sel;
    logic [6:0]            seg;

    modport master (
        output start, qty, paper, jam, lid, cancel,
        input  copying, no_paper, jammed, done, remaining, tray_sel, seg
    );

    modport slave (
        input  start, qty, paper, jam, lid, cancel,
        output copying, no_paper, jammed, done, remaining, tray_sel, seg
    );
endinterface

// File: rtl/copier_ctrl_multi.sv
// Multi-tray photocopier controller: N-copy job with tray failover, multi-cycle
// sheet feed, lid pause, jam/no-paper recovery and cancel. Outputs decode registers.
module copier_ctrl_multi #(
    parameter int COUNT_BITS  = 4,
    parameter int NTRAYS      = 2,
    parameter int COPY_CYCLES = 3
) (
    input logic                clk_2,
    input logic                reset,
    copier_ctrl_multi_if.slave bus
);
    localparam int TRAY_BITS  = (NTRAYS > 1) ? $clog2(NTRAYS) : 1;
    localparam int PHASE_BITS = (COPY_CYCLES > 1) ? $clog2(COPY_CYCLES) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FEED     = 3'd1;
    localparam logic [2:0] S_JAM      = 3'd2;
    localparam logic [2:0] S_NO_PAPER = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]            r_state;
    logic [COUNT_BITS-1:0] r_remaining;
    logic [PHASE_BITS-1:0] r_phase;
    logic [TRAY_BITS-1:0]  r_tray;

    logic                  w_none;
    logic [TRAY_BITS-1:0]  w_first;
    logic                  w_tray_has_paper;
    logic                  w_last_phase;
    logic [6:0]            w_seg;

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        w_first = '0;
        for (int i = NTRAYS - 1; i >= 0; i--) begin
            if (bus.paper[i]) w_first = TRAY_BITS'(i);
        end
    end

    assign w_none           = (bus.paper == '0);
    assign w_tray_has_paper = bus.paper[r_tray];
    assign w_last_phase     = (r_phase == PHASE_BITS'(COPY_CYCLES - 1));

    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_phase     <= '0;
            r_tray      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && (bus.qty != '0)) begin
                        r_remaining <= bus.qty;
                        r_phase     <= '0;
                        if (w_none) begin
                            r_state <= S_NO_PAPER;
                        end else begin
                            r_tray  <= w_first;
                            r_state <= S_FEED;
                        end
                    end
                end

                // One action per cycle, in fixed priority: cancel, jam, tray empty, lid, advance.
                S_FEED: begin
                    if (bus.cancel) begin
                        r_state <= S_DONE;
                    end else if (bus.jam) begin
                        r_state <= S_JAM;
                        r_phase <= '0;
                    end else if (!w_tray_has_paper) begin
                        r_phase <= '0;
                        if (w_none) r_state <= S_NO_PAPER;
                        else        r_tray  <= w_first;
                    end else if (!bus.lid) begin
                        if (w_last_phase) begin
                            r_phase <= '0;
                            if (r_remaining != '0) begin
                                r_remaining <= r_remaining - COUNT_BITS'(1);
                            end
                            if (r_remaining == COUNT_BITS'(1)) r_state <= S_DONE;
                        end else begin
                            r_phase <= r_phase + PHASE_BITS'(1);
                        end
                    end
                end

                // Opening and re-closing the lid clears the jam; the stuck sheet is reprinted.
                S_JAM: begin
                    if (bus.cancel) begin
                        r_state <= S_DONE;
                    end else if (bus.lid && !bus.jam) begin
                        r_state <= S_FEED;
                        r_phase <= '0;
                    end
                end

                S_NO_PAPER: begin
                    if (bus.cancel) begin
                        r_state <= S_DONE;
                    end else if (!w_none) begin
                        r_tray  <= w_first;
                        r_phase <= '0;
                        r_state <= S_FEED;
                    end
                end

                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_seg = 7'b0111111;
        case (r_state)
            S_IDLE:     w_seg = 7'b0111111;
            S_FEED:     w_seg = 7'b0000110;
            S_JAM:      w_seg = 7'b1011011;
            S_NO_PAPER: w_seg = 7'b1001111;
            S_DONE:     w_seg = 7'b1100110;
            default:    w_seg = 7'b0111111;
        endcase
    end

    assign bus.copying   = (r_state == S_FEED);
    assign bus.no_paper  = (r_state == S_NO_PAPER);
    assign bus.jammed    = (r_state == S_JAM);
    assign bus.done      = (r_state == S_DONE);
    assign bus.remaining = r_remaining;
    assign bus.tray_sel  = r_tray;
    assign bus.seg       = w_seg;
endmodule
